bubsysrom_palette: RTL and testbench



---
 rtl/bubsysrom_pkg.sv | 42 ++++
 rtl/bubsysrom_cram_dp.sv | 49 ++++
 rtl/bubsysrom_palette.sv | 223 ++++++++++++++++++++++
 tb/tb_bubsysrom_palette.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bubsysrom_pkg.sv
// Shared definitions for the bubsysrom palette block: color RAM geometry,
// palette entry field layout and the CPU-port state machine encoding.
// Optional feature macro: BUBSYSROM_PALETTE_CLEAR_EN adds a CLEAR state.
package bubsysrom_pkg;

    localparam int CRAM_AW_DEF = 11;
    localparam int DATA_W      = 16;
    localparam int COLOR_W     = 5;

    // Palette entry layout: bit15 unused, [14:10] B, [9:5] G, [4:0] R
    localparam int R_LSB = 0;
    localparam int G_LSB = 5;
    localparam int B_LSB = 10;

`ifdef BUBSYSROM_PALETTE_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_CLEAR = 2'd3
    } cram_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } cram_state_t;
`endif

    function automatic logic [COLOR_W-1:0] color_r(input logic [DATA_W-1:0] entry);
        return entry[R_LSB +: COLOR_W];
    endfunction

    function automatic logic [COLOR_W-1:0] color_g(input logic [DATA_W-1:0] entry);
        return entry[G_LSB +: COLOR_W];
    endfunction

    function automatic logic [COLOR_W-1:0] color_b(input logic [DATA_W-1:0] entry);
        return entry[B_LSB +: COLOR_W];
    endfunction

endpackage

// File: rtl/bubsysrom_cram_dp.sv
// True dual-port color RAM. Port A (CPU side) has byte enables, a registered
// read with a synchronous clear, and read-first behaviour. Port B (video side)
// is a read-only registered port; a same-edge write on port A returns the
// old contents on port B.
module bubsysrom_cram_dp
    import bubsysrom_pkg::*;
#(
    parameter int AW = CRAM_AW_DEF
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              a_re,
    input  logic              a_we,
    input  logic [1:0]        a_be,
    input  logic [AW-1:0]     a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    input  logic              b_en,
    input  logic [AW-1:0]     b_addr,
    output logic [DATA_W-1:0] b_dout
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    // Port A byte-enabled write
    always_ff @(posedge clk) begin
        if (a_we) begin
            if (a_be[1]) mem[a_addr][15:8] <= a_din[15:8];
            if (a_be[0]) mem[a_addr][7:0]  <= a_din[7:0];
        end
    end

    // Port A read register, cleared while reset or RAM clear is active
    always_ff @(posedge clk) begin
        if (a_rst) begin
            a_dout <= '0;
        end else if (a_re) begin
            a_dout <= mem[a_addr];
        end
    end

    // Port B read register, loaded only on the video read slot
    always_ff @(posedge clk) begin
        if (b_en) begin
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/bubsysrom_palette.sv
// Palette stage: CPU-writable color RAM that converts the video stage's
// palette index into 5:5:5 RGB with exactly one pixel of latency, with sync
// and blank delayed to stay aligned with the color.
// Optional feature macro: BUBSYSROM_PALETTE_CLEAR_EN -- when defined, reset
// enters a CLEAR state that zeroes the whole color RAM before the CPU port
// becomes usable; when undefined, RAM contents survive reset.
module bubsysrom_palette
    import bubsysrom_pkg::*;
#(
    parameter int CRAM_AW = CRAM_AW_DEF
) (
    input  logic               i_EMU_MCLK,
    input  logic               i_EMU_INITRST_n,
    input  logic               i_EMU_CLK6MPCEN_n,
    input  logic [CRAM_AW-1:0] i_CD,
    input  logic               i_VBLANK_n,
    input  logic               i_CSYNC_n,
    input  logic [CRAM_AW-1:0] i_CPU_ADDR,
    input  logic [DATA_W-1:0]  i_CPU_DIN,
    output logic [DATA_W-1:0]  o_CPU_DOUT,
    input  logic               i_CPU_RW,
    input  logic               i_CPU_UDS_n,
    input  logic               i_CPU_LDS_n,
    input  logic               i_CRCS_n,
    output logic [COLOR_W-1:0] o_VIDEO_R,
    output logic [COLOR_W-1:0] o_VIDEO_G,
    output logic [COLOR_W-1:0] o_VIDEO_B,
    output logic               o_CSYNC_n,
    output logic               o_BLANK_n
);

    logic ce;
    assign ce = ~i_EMU_CLK6MPCEN_n;

    // ------------------------------------------------------------------
    // CPU port control
    // ------------------------------------------------------------------
    cram_state_t state, state_nxt;

    logic               armed;
    logic               write_req;
    logic               start_write;
    logic               clearing;
    logic [CRAM_AW-1:0] wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [1:0]         wr_be;

    logic               ram_we;
    logic [1:0]         ram_be;
    logic [CRAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0]  ram_din;
    logic               ram_re;
    logic               ram_rst;

`ifdef BUBSYSROM_PALETTE_CLEAR_EN
    logic [CRAM_AW-1:0] clr_addr;
`endif

    assign write_req = ~i_CRCS_n & ~i_CPU_RW & (~i_CPU_UDS_n | ~i_CPU_LDS_n);

    // FSM state register; reset aborts any write in flight
    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_INITRST_n) begin
`ifdef BUBSYSROM_PALETTE_CLEAR_EN
            state <= ST_CLEAR;
`else
            state <= ST_IDLE;
`endif
        end else begin
            state <= state_nxt;
        end
    end

    // A chip select that was already low at reset release must be seen high
    // once before it can start a write
    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_INITRST_n) begin
            armed <= 1'b0;
        end else if (i_CRCS_n) begin
            armed <= 1'b1;
        end
    end

    // Capture address, data and byte enables at the start of the access so
    // later bus changes within the same select cannot alter the write
    always_ff @(posedge i_EMU_MCLK) begin
        if (start_write) begin
            wr_addr <= i_CPU_ADDR;
            wr_data <= i_CPU_DIN;
            wr_be   <= {~i_CPU_UDS_n, ~i_CPU_LDS_n};
        end
    end

`ifdef BUBSYSROM_PALETTE_CLEAR_EN
    // Clear address walks 0..2047 while in CLEAR; reset restarts it at 0
    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_INITRST_n) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + {{(CRAM_AW-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Next-state and port A control
    always_comb begin
        state_nxt   = state;
        start_write = 1'b0;
        clearing    = 1'b0;
        ram_we      = 1'b0;
        ram_be      = wr_be;
        ram_addr    = i_CPU_ADDR;
        ram_din     = wr_data;
        case (state)
            ST_IDLE: begin
                if (armed && write_req) begin
                    start_write = 1'b1;
                    state_nxt   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = wr_addr;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_CRCS_n) state_nxt = ST_IDLE;
            end
`ifdef BUBSYSROM_PALETTE_CLEAR_EN
            ST_CLEAR: begin
                clearing = 1'b1;
                ram_we   = 1'b1;
                ram_be   = 2'b11;
                ram_addr = clr_addr;
                ram_din  = '0;
                if (clr_addr == '1) state_nxt = ST_IDLE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (!i_EMU_INITRST_n) begin
            ram_we      = 1'b0;
            start_write = 1'b0;
        end
    end

    assign ram_re  = ~i_CRCS_n & i_CPU_RW & ~clearing;
    assign ram_rst = ~i_EMU_INITRST_n | clearing;

    // ------------------------------------------------------------------
    // Video pipeline
    // ------------------------------------------------------------------
    logic [CRAM_AW-1:0] cd_p0;
    logic               vblank_n_p0;
    logic               csync_n_p0;
    logic               vld_p0;
    logic [DATA_W-1:0]  pix_p1;

    // Stage p0: palette index latched on the pixel enable
    always_ff @(posedge i_EMU_MCLK) begin
        if (ce) begin
            cd_p0 <= i_CD;
        end
    end

    // Stage p0: sync/blank latched with the index; vld_p0 marks the RAM read slot
    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_INITRST_n) begin
            vld_p0      <= 1'b0;
            vblank_n_p0 <= 1'b0;
            csync_n_p0  <= 1'b1;
        end else begin
            vld_p0 <= ce;
            if (ce) begin
                vblank_n_p0 <= i_VBLANK_n;
                csync_n_p0  <= i_CSYNC_n;
            end
        end
    end

    // Stage p1: color RAM lookup one MCLK after the pixel enable (inside RAM)
    bubsysrom_cram_dp #(
        .AW (CRAM_AW)
    ) u_cram (
        .clk    (i_EMU_MCLK),
        .a_rst  (ram_rst),
        .a_re   (ram_re),
        .a_we   (ram_we),
        .a_be   (ram_be),
        .a_addr (ram_addr),
        .a_din  (ram_din),
        .a_dout (o_CPU_DOUT),
        .b_en   (vld_p0),
        .b_addr (cd_p0),
        .b_dout (pix_p1)
    );

    // Stage p2: outputs update on the next pixel enable and hold in between
    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_INITRST_n) begin
            o_VIDEO_R <= '0;
            o_VIDEO_G <= '0;
            o_VIDEO_B <= '0;
            o_CSYNC_n <= 1'b1;
            o_BLANK_n <= 1'b0;
        end else if (ce) begin
            if (vblank_n_p0) begin
                o_VIDEO_R <= color_r(pix_p1);
                o_VIDEO_G <= color_g(pix_p1);
                o_VIDEO_B <= color_b(pix_p1);
            end else begin
                o_VIDEO_R <= '0;
                o_VIDEO_G <= '0;
                o_VIDEO_B <= '0;
            end
            o_BLANK_n <= vblank_n_p0;
            o_CSYNC_n <= csync_n_p0;
        end
    end

endmodule

// File: tb/tb_bubsysrom_palette.sv
// Directed self-checking bench for bubsysrom_palette. Inputs change on the
// falling MCLK edge, outputs are sampled on the falling edge.
// Honours BUBSYSROM_PALETTE_CLEAR_EN when the design is built with it.
module tb_bubsysrom_palette;

    logic        clk;
    logic        rst_n;
    logic        cen_n;
    logic [10:0] cd;
    logic        vblank_n;
    logic        csync_in;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_rw;
    logic        uds_n;
    logic        lds_n;
    logic        crcs_n;
    logic [4:0]  vid_r;
    logic [4:0]  vid_g;
    logic [4:0]  vid_b;
    logic        csync_out;
    logic        blank_out;
    logic [15:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    assign rgb = {1'b0, vid_b, vid_g, vid_r};

    bubsysrom_palette dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_INITRST_n   (rst_n),
        .i_EMU_CLK6MPCEN_n (cen_n),
        .i_CD              (cd),
        .i_VBLANK_n        (vblank_n),
        .i_CSYNC_n         (csync_in),
        .i_CPU_ADDR        (cpu_addr),
        .i_CPU_DIN         (cpu_din),
        .o_CPU_DOUT        (cpu_dout),
        .i_CPU_RW          (cpu_rw),
        .i_CPU_UDS_n       (uds_n),
        .i_CPU_LDS_n       (lds_n),
        .i_CRCS_n          (crcs_n),
        .o_VIDEO_R         (vid_r),
        .o_VIDEO_G         (vid_g),
        .o_VIDEO_B         (vid_b),
        .o_CSYNC_n         (csync_out),
        .o_BLANK_n         (blank_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic mclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One pixel period of three MCLKs; the pixel enable is on the first edge
    task automatic pix();
        cen_n = 1'b0;
        @(negedge clk);
        cen_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_clear();
`ifdef BUBSYSROM_PALETTE_CLEAR_EN
        mclk(2052);
`endif
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [15:0] d,
                             input logic u_n, input logic l_n);
        cpu_addr = a;
        cpu_din  = d;
        cpu_rw   = 1'b0;
        uds_n    = u_n;
        lds_n    = l_n;
        crcs_n   = 1'b0;
        mclk(2);
        crcs_n   = 1'b1;
        cpu_rw   = 1'b1;
        uds_n    = 1'b1;
        lds_n    = 1'b1;
        mclk(2);
    endtask

    task automatic cpu_read(input string tag, input logic [10:0] a, input logic [15:0] exp);
        cpu_addr = a;
        cpu_rw   = 1'b1;
        uds_n    = 1'b0;
        lds_n    = 1'b0;
        crcs_n   = 1'b0;
        mclk(1);
        check({tag, "_1clk"}, cpu_dout, exp);
        mclk(1);
        check({tag, "_held"}, cpu_dout, exp);
        crcs_n   = 1'b1;
        uds_n    = 1'b1;
        lds_n    = 1'b1;
        mclk(1);
    endtask

    initial begin
        rst_n    = 1'b0;
        cen_n    = 1'b1;
        cd       = '0;
        vblank_n = 1'b1;
        csync_in = 1'b1;
        cpu_addr = '0;
        cpu_din  = '0;
        cpu_rw   = 1'b1;
        uds_n    = 1'b1;
        lds_n    = 1'b1;
        crcs_n   = 1'b1;

        // Reset state, with a pixel enable occurring during reset
        mclk(2);
        pix();
        check("rst_rgb", rgb, 16'h0000);
        check("rst_dout", cpu_dout, 16'h0000);
        check("rst_csync", {15'd0, csync_out}, 16'h0001);
        check("rst_blank", {15'd0, blank_out}, 16'h0000);
        rst_n = 1'b1;
        wait_clear();
        mclk(2);

        // Full-word write then lookup: R=31, G=0, B=31 one pixel later
        cpu_write(11'h005, 16'h7C1F, 1'b0, 1'b0);
        cd = 11'h005; vblank_n = 1'b1; csync_in = 1'b1;
        pix();
        pix();
        check("rgb_7c1f", rgb, 16'h7C1F);
        check("blank_active", {15'd0, blank_out}, 16'h0001);
        check("csync_high", {15'd0, csync_out}, 16'h0001);

        // No pixel enable: outputs hold even though inputs change
        cd = 11'h000; vblank_n = 1'b0; csync_in = 1'b0;
        mclk(5);
        check("hold_rgb", rgb, 16'h7C1F);
        check("hold_blank", {15'd0, blank_out}, 16'h0001);

        // Lower-byte-only write merges with stored upper byte
        cpu_write(11'h005, 16'h00FF, 1'b1, 1'b0);
        cpu_read("rd_lds", 11'h005, 16'h7CFF);

        // Upper-byte-only write
        cpu_write(11'h007, 16'hFFFF, 1'b0, 1'b0);
        cpu_write(11'h007, 16'h1200, 1'b0, 1'b1);
        cpu_read("rd_uds", 11'h007, 16'h12FF);

        // Select held low 20 MCLK with data changing: only the first value lands
        cpu_addr = 11'h006;
        cpu_din  = 16'h1234;
        cpu_rw   = 1'b0;
        uds_n    = 1'b0;
        lds_n    = 1'b0;
        crcs_n   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cpu_din = cpu_din + 16'h0101;
        end
        crcs_n = 1'b1; cpu_rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        mclk(2);
        cpu_read("rd_long_cs", 11'h006, 16'h1234);
        cpu_write(11'h006, 16'h0ABC, 1'b0, 1'b0);
        cpu_read("rd_rewrite", 11'h006, 16'h0ABC);

        // Vertical blank and sync: CSYNC change lags its input by one pixel
        cd = 11'h005; vblank_n = 1'b0; csync_in = 1'b0;
        pix();
        check("csync_lag", {15'd0, csync_out}, 16'h0001);
        pix();
        check("vblank_rgb", rgb, 16'h0000);
        check("vblank_blank", {15'd0, blank_out}, 16'h0000);
        check("csync_low", {15'd0, csync_out}, 16'h0000);
        vblank_n = 1'b1; csync_in = 1'b1;
        pix();
        pix();
        check("rgb_7cff", rgb, 16'h7CFF);
        check("blank_back", {15'd0, blank_out}, 16'h0001);

        // CPU write on the same edge as the video read of that entry
        cpu_write(11'h010, 16'h001F, 1'b0, 1'b0);
        cd       = 11'h010;
        cpu_addr = 11'h010;
        cpu_din  = 16'h03E0;
        cpu_rw   = 1'b0;
        uds_n    = 1'b0;
        lds_n    = 1'b0;
        crcs_n   = 1'b0;
        cen_n    = 1'b0;
        @(negedge clk);
        cen_n = 1'b1;
        @(negedge clk);
        crcs_n = 1'b1; cpu_rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(negedge clk);
        pix();
        check("collide_old", rgb, 16'h001F);
        pix();
        check("collide_new", rgb, 16'h03E0);

        // Reset in the WRITE cycle aborts the write; select still low after
        // release must not start a new one
        cpu_write(11'h020, 16'h1111, 1'b0, 1'b0);
        cpu_addr = 11'h020;
        cpu_din  = 16'h2222;
        cpu_rw   = 1'b0;
        uds_n    = 1'b0;
        lds_n    = 1'b0;
        crcs_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_rgb", rgb, 16'h0000);
        check("rst2_dout", cpu_dout, 16'h0000);
        check("rst2_csync", {15'd0, csync_out}, 16'h0001);
        check("rst2_blank", {15'd0, blank_out}, 16'h0000);
        rst_n   = 1'b1;
        cpu_din = 16'h3333;
        wait_clear();
        mclk(4);
        crcs_n = 1'b1; cpu_rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        mclk(2);
`ifdef BUBSYSROM_PALETTE_CLEAR_EN
        cpu_read("rd_abort", 11'h020, 16'h0000);
`else
        cpu_read("rd_abort", 11'h020, 16'h1111);
`endif
        cpu_write(11'h020, 16'h4444, 1'b0, 1'b0);
        cpu_read("rd_after_rst", 11'h020, 16'h4444);

`ifdef BUBSYSROM_PALETTE_CLEAR_EN
        // One-MCLK reset clears the whole RAM, including the last entry
        cpu_write(11'h7FF, 16'hABCD, 1'b0, 1'b0);
        cpu_read("rd_preload", 11'h7FF, 16'hABCD);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cpu_addr = 11'h7FF;
        cpu_rw   = 1'b1;
        crcs_n   = 1'b0;
        mclk(10);
        check("clear_dout", cpu_dout, 16'h0000);
        crcs_n = 1'b1;
        mclk(2048);
        cpu_read("rd_cleared", 11'h7FF, 16'h0000);
`else
        // Contents written before the earlier reset survive it
        cpu_read("rd_survive5", 11'h005, 16'h7CFF);
        cpu_read("rd_survive10", 11'h010, 16'h03E0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
